lsu: RTL and testbench



---
 rtl/lsu.sv | 189 ++++++++++++++++++
 tb/tb_lsu.sv | 399 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lsu.sv
// Load/store unit: one aligned byte/half/word access per request over a
// valid/ack memory port, with alignment, size and timeout faults.
module lsu #(
  parameter int XLEN    = 32,
  parameter int TIMEOUT = 255
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic            is_store,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] addr,
  input  logic [XLEN-1:0] store_data,
  output logic            mem_req,
  output logic            mem_we,
  output logic [XLEN-1:0] mem_addr,
  output logic [3:0]      mem_wstrb,
  output logic [XLEN-1:0] mem_wdata,
  input  logic            mem_ack,
  input  logic [XLEN-1:0] mem_rdata,
  output logic            done_valid,
  output logic [XLEN-1:0] load_data,
  output logic            fault_valid,
  output logic [1:0]      fault_cause,
  output logic            dbg_state
);

  // Handshakes: a request is taken on a clock edge where req_valid && req_ready;
  // the memory request is held until the edge where mem_req && mem_ack.
  typedef enum logic {S_IDLE = 1'b0, S_ACCESS = 1'b1} state_t;

  localparam logic [1:0] C_MISALIGN = 2'b01;
  localparam logic [1:0] C_ILLEGAL  = 2'b10;
  localparam logic [1:0] C_TIMEOUT  = 2'b11;

  localparam bit TO_EN = (TIMEOUT > 0);
  localparam int CW    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] TO_LAST = CW'(TO_EN ? TIMEOUT - 1 : 0);

  state_t         r_state;
  logic [CW-1:0]  r_cnt;
  logic [1:0]     r_off;
  logic [2:0]     r_funct3;
  logic           r_store;

  logic           w_legal;
  logic           w_misalign;
  logic [1:0]     w_cause;
  logic [3:0]     w_wstrb;
  logic [31:0]    w_wdata;
  logic [7:0]     w_byte;
  logic [15:0]    w_half;
  logic [31:0]    w_load;
  logic           w_timeout_hit;

  assign req_ready     = (r_state == S_IDLE);
  assign dbg_state     = r_state;
  assign w_timeout_hit = TO_EN && (r_cnt == TO_LAST);

  // Request checking: an illegal size outranks a misaligned address.
  always_comb begin
    w_legal    = 1'b0;
    w_misalign = 1'b0;
    w_cause    = 2'b00;
    if (is_store) begin
      w_legal = (funct3 == 3'b000) || (funct3 == 3'b001) || (funct3 == 3'b010);
    end else begin
      w_legal = (funct3 == 3'b000) || (funct3 == 3'b001) || (funct3 == 3'b010) ||
                (funct3 == 3'b100) || (funct3 == 3'b101);
    end
    case (funct3[1:0])
      2'b01:   w_misalign = addr[0];
      2'b10:   w_misalign = (addr[1:0] != 2'b00);
      default: w_misalign = 1'b0;
    endcase
    if (!w_legal) begin
      w_cause = C_ILLEGAL;
    end else if (w_misalign) begin
      w_cause = C_MISALIGN;
    end
  end

  always_comb begin
    w_wstrb = 4'b1111;
    w_wdata = store_data;
    case (funct3[1:0])
      2'b00: begin
        w_wstrb = 4'b0001 << addr[1:0];
        w_wdata = {4{store_data[7:0]}};
      end
      2'b01: begin
        w_wstrb = 4'b0011 << addr[1:0];
        w_wdata = {2{store_data[15:0]}};
      end
      default: begin
        w_wstrb = 4'b1111;
        w_wdata = store_data;
      end
    endcase
  end

  // Load formatting uses the offset and size latched at accept time.
  always_comb begin
    w_byte = 8'h00;
    case (r_off)
      2'd0: w_byte = mem_rdata[7:0];
      2'd1: w_byte = mem_rdata[15:8];
      2'd2: w_byte = mem_rdata[23:16];
      2'd3: w_byte = mem_rdata[31:24];
      default: w_byte = 8'h00;
    endcase
    w_half = r_off[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    case (r_funct3)
      3'b000:  w_load = {{24{w_byte[7]}}, w_byte};
      3'b100:  w_load = {24'h000000, w_byte};
      3'b001:  w_load = {{16{w_half[15]}}, w_half};
      3'b101:  w_load = {16'h0000, w_half};
      default: w_load = mem_rdata;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_off       <= 2'b00;
      r_funct3    <= 3'b000;
      r_store     <= 1'b0;
      mem_req     <= 1'b0;
      mem_we      <= 1'b0;
      mem_addr    <= '0;
      mem_wstrb   <= 4'b0000;
      mem_wdata   <= '0;
      done_valid  <= 1'b0;
      load_data   <= '0;
      fault_valid <= 1'b0;
      fault_cause <= 2'b00;
    end else begin
      done_valid  <= 1'b0;
      fault_valid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (req_valid) begin
            if (w_cause != 2'b00) begin
              fault_valid <= 1'b1;
              fault_cause <= w_cause;
            end else begin
              r_state   <= S_ACCESS;
              r_cnt     <= '0;
              r_off     <= addr[1:0];
              r_funct3  <= funct3;
              r_store   <= is_store;
              mem_req   <= 1'b1;
              mem_we    <= is_store;
              mem_addr  <= {addr[31:2], 2'b00};
              mem_wstrb <= is_store ? w_wstrb : 4'b0000;
              mem_wdata <= is_store ? w_wdata : 32'h0;
            end
          end
        end
        S_ACCESS: begin
          // An ack on the last allowed cycle still completes the access.
          if (mem_ack) begin
            r_state    <= S_IDLE;
            r_cnt      <= '0;
            mem_req    <= 1'b0;
            mem_we     <= 1'b0;
            mem_wstrb  <= 4'b0000;
            done_valid <= 1'b1;
            load_data  <= r_store ? 32'h0 : w_load;
          end else if (w_timeout_hit) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            mem_req     <= 1'b0;
            mem_we      <= 1'b0;
            mem_wstrb   <= 4'b0000;
            fault_valid <= 1'b1;
            fault_cause <= C_TIMEOUT;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lsu.sv
// Directed bench for lsu: a transaction-level reference model checked every
// cycle, plus hand-computed literal expectations per scenario.
module tb_lsu;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        is_store;
  logic [2:0]  funct3;
  logic [31:0] addr;
  logic [31:0] store_data;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_wdata;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic        done_valid;
  logic [31:0] load_data;
  logic        fault_valid;
  logic [1:0]  fault_cause;
  logic        dbg_state;

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_en   = 1'b0;

  logic [31:0] exp_q[$];

  lsu #(.XLEN(32), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .is_store(is_store), .funct3(funct3), .addr(addr), .store_data(store_data),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wstrb(mem_wstrb),
    .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .done_valid(done_valid), .load_data(load_data), .fault_valid(fault_valid),
    .fault_cause(fault_cause), .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic int size_bytes(input logic [2:0] f3);
    case (f3 % 4)
      0:       return 1;
      1:       return 2;
      default: return 4;
    endcase
  endfunction

  function automatic logic [1:0] m_cause(input logic st, input logic [2:0] f3, input logic [31:0] a);
    bit legal;
    if (st) legal = (f3 == 0 || f3 == 1 || f3 == 2);
    else    legal = (f3 == 0 || f3 == 1 || f3 == 2 || f3 == 4 || f3 == 5);
    if (!legal) return 2'd2;
    if ((a % size_bytes(f3)) != 0) return 2'd1;
    return 2'd0;
  endfunction

  function automatic logic [3:0] m_wstrb(input logic [2:0] f3, input logic [31:0] a);
    int n;
    n = size_bytes(f3);
    return 4'(((1 << n) - 1) << (a % 4));
  endfunction

  function automatic logic [31:0] m_wdata(input logic [2:0] f3, input logic [31:0] sd);
    case (size_bytes(f3))
      1:       return (sd & 32'hFF) * 32'h0101_0101;
      2:       return (sd & 32'hFFFF) * 32'h0001_0001;
      default: return sd;
    endcase
  endfunction

  function automatic logic [31:0] m_load(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] rd);
    logic [31:0] v;
    bit          uns;
    uns = (f3 >= 4);
    v   = rd >> (8 * (a % 4));
    case (size_bytes(f3))
      1: begin
        v = v & 32'hFF;
        if (!uns && v >= 32'h80) v = v | 32'hFFFF_FF00;
      end
      2: begin
        v = v & 32'hFFFF;
        if (!uns && v >= 32'h8000) v = v | 32'hFFFF_0000;
      end
      default: v = rd;
    endcase
    return v;
  endfunction

  bit          m_busy = 1'b0;
  int          m_wait = 0;
  logic        m_st;
  logic [2:0]  m_f3;
  logic [31:0] m_a;
  logic        e_ready, e_req, e_we, e_done, e_fault;
  logic [31:0] e_addr, e_wdata;
  logic [3:0]  e_wstrb;
  logic [1:0]  e_cause;

  // Predicts next-cycle outputs from the inputs seen at this edge.
  always @(posedge clk) begin
    logic [1:0] c;
    e_done  = 1'b0;
    e_fault = 1'b0;
    if (rst) begin
      m_busy = 1'b0;
      m_wait = 0;
    end else if (m_busy) begin
      m_wait++;
      if (mem_ack) begin
        e_done = 1'b1;
        exp_q.push_back(m_st ? 32'h0 : m_load(m_f3, m_a, mem_rdata));
        m_busy = 1'b0;
      end else if (TO > 0 && m_wait == TO) begin
        e_fault = 1'b1;
        e_cause = 2'd3;
        m_busy  = 1'b0;
      end
    end else if (req_valid) begin
      c = m_cause(is_store, funct3, addr);
      if (c != 0) begin
        e_fault = 1'b1;
        e_cause = c;
      end else begin
        m_busy  = 1'b1;
        m_wait  = 0;
        m_st    = is_store;
        m_f3    = funct3;
        m_a     = addr;
        e_addr  = addr - (addr % 4);
        e_we    = is_store;
        e_wstrb = is_store ? m_wstrb(funct3, addr) : 4'b0000;
        e_wdata = m_wdata(funct3, store_data);
      end
    end
    e_req   = m_busy;
    e_ready = !m_busy;
  end

  // ---------------- scoreboard / compare ----------------
  always @(negedge clk) begin
    logic [31:0] exp_v;
    if (chk_en) begin
      check("req_ready", 32'(req_ready), 32'(e_ready));
      check("mem_req", 32'(mem_req), 32'(e_req));
      check("done_valid", 32'(done_valid), 32'(e_done));
      check("fault_valid", 32'(fault_valid), 32'(e_fault));
      if (e_req) begin
        check("mem_we", 32'(mem_we), 32'(e_we));
        check("mem_addr", mem_addr, e_addr);
        check("mem_wstrb", 32'(mem_wstrb), 32'(e_wstrb));
        if (e_we) check("mem_wdata", mem_wdata, e_wdata);
      end
      if (e_fault) check("fault_cause", 32'(fault_cause), 32'(e_cause));
      if (done_valid) begin
        if (exp_q.size() == 0) begin
          check("done_unexpected", 32'(done_valid), 32'h0);
        end else begin
          exp_v = exp_q.pop_front();
          check("load_data", load_data, exp_v);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic put_req(input logic st, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] sd);
    req_valid  = 1'b1;
    is_store   = st;
    funct3     = f3;
    addr       = a;
    store_data = sd;
  endtask

  // Returns in the cycle where done_valid is expected.
  task automatic run_access(input logic st, input logic [2:0] f3, input logic [31:0] a,
                            input logic [31:0] sd, input logic [31:0] rd, input int lat,
                            input logic [31:0] lit);
    put_req(st, f3, a, sd);
    step();
    req_valid = 1'b0;
    repeat (lat) step();
    mem_ack   = 1'b1;
    mem_rdata = rd;
    step();
    mem_ack   = 1'b0;
    mem_rdata = $urandom_range(0, 32'hFFFF);
    @(negedge clk);
    check("vec_done", 32'(done_valid), 32'h1);
    check("vec_no_fault", 32'(fault_valid), 32'h0);
    check("vec_load_data", load_data, lit);
  endtask

  task automatic fault_req(input logic st, input logic [2:0] f3, input logic [31:0] a,
                           input logic [1:0] cause);
    put_req(st, f3, a, 32'h0);
    step();
    req_valid = 1'b0;
    @(negedge clk);
    check("flt_valid", 32'(fault_valid), 32'h1);
    check("flt_cause", 32'(fault_cause), 32'(cause));
    check("flt_no_mem_req", 32'(mem_req), 32'h0);
    check("flt_ready", 32'(req_ready), 32'h1);
    step();
    @(negedge clk);
    check("flt_mem_req_after", 32'(mem_req), 32'h0);
  endtask

  typedef struct {
    logic        st;
    logic [2:0]  f3;
    logic [31:0] a;
    logic [31:0] sd;
    logic [31:0] rd;
    int          lat;
    logic [31:0] lit;
  } vec_t;

  vec_t vecs[8];

  initial begin
    vecs[0] = '{1'b0, 3'b001, 32'h202, 32'h0, 32'h8001_7FFF, 1, 32'hFFFF_8001};
    vecs[1] = '{1'b0, 3'b001, 32'h200, 32'h0, 32'h8001_7FFF, 0, 32'h0000_7FFF};
    vecs[2] = '{1'b0, 3'b000, 32'h000, 32'h0, 32'h0000_00F0, 0, 32'hFFFF_FFF0};
    vecs[3] = '{1'b0, 3'b100, 32'h001, 32'h0, 32'h0000_F000, 2, 32'h0000_00F0};
    vecs[4] = '{1'b0, 3'b010, 32'h03C, 32'h0, 32'hDEAD_BEEF, 2, 32'hDEAD_BEEF};
    vecs[5] = '{1'b1, 3'b000, 32'h011, 32'h1234_5678, 32'h0, 0, 32'h0};
    vecs[6] = '{1'b1, 3'b010, 32'h004, 32'hCAFE_F00D, 32'h0, TO - 1, 32'h0};
    vecs[7] = '{1'b0, 3'b101, 32'h006, 32'h0, 32'hA5A5_7E01, TO - 1, 32'h0000_A5A5};
  end

  // ---------------- stimulus ----------------
  initial begin
    rst = 1'b1; req_valid = 1'b0; is_store = 1'b0; funct3 = 3'b000;
    addr = 32'h0; store_data = 32'h0; mem_ack = 1'b0; mem_rdata = 32'h0;
    step();
    chk_en = 1'b1;
    step();
    @(negedge clk);
    check("rst_mem_req", 32'(mem_req), 32'h0);
    check("rst_req_ready", 32'(req_ready), 32'h1);
    check("rst_done", 32'(done_valid), 32'h0);
    check("rst_fault", 32'(fault_valid), 32'h0);
    check("rst_mem_addr", mem_addr, 32'h0);
    check("rst_mem_wdata", mem_wdata, 32'h0);
    check("rst_mem_wstrb", 32'(mem_wstrb), 32'h0);
    check("rst_load_data", load_data, 32'h0);
    check("rst_fault_cause", 32'(fault_cause), 32'h0);
    rst = 1'b0;
    step();

    // LB 0x103, ack at T+1
    put_req(1'b0, 3'b000, 32'h103, 32'h0);
    step();
    req_valid = 1'b0; mem_ack = 1'b1; mem_rdata = 32'h80FF_1234;
    @(negedge clk);
    check("lb_mem_req", 32'(mem_req), 32'h1);
    check("lb_mem_addr", mem_addr, 32'h100);
    check("lb_wstrb", 32'(mem_wstrb), 32'h0);
    check("lb_we", 32'(mem_we), 32'h0);
    step();
    mem_ack = 1'b0;
    @(negedge clk);
    check("lb_done", 32'(done_valid), 32'h1);
    check("lb_data", load_data, 32'hFFFF_FF80);
    run_access(1'b0, 3'b100, 32'h103, 32'h0, 32'h80FF_1234, 0, 32'h0000_0080);
    step();

    // SH 0x22
    put_req(1'b1, 3'b001, 32'h22, 32'hAAAA_BEEF);
    step();
    req_valid = 1'b0;
    @(negedge clk);
    check("sh_we", 32'(mem_we), 32'h1);
    check("sh_wstrb", 32'(mem_wstrb), 32'hC);
    check("sh_wdata", mem_wdata, 32'hBEEF_BEEF);
    check("sh_addr", mem_addr, 32'h20);
    mem_ack = 1'b1;
    step();
    mem_ack = 1'b0;
    @(negedge clk);
    check("sh_done", 32'(done_valid), 32'h1);
    check("sh_load_data", load_data, 32'h0);
    step();

    // faults, including illegal-before-misaligned priority
    fault_req(1'b0, 3'b010, 32'h06, 2'd1);
    fault_req(1'b0, 3'b011, 32'h00, 2'd2);
    fault_req(1'b0, 3'b110, 32'h00, 2'd2);
    fault_req(1'b0, 3'b111, 32'h00, 2'd2);
    fault_req(1'b1, 3'b100, 32'h00, 2'd2);
    fault_req(1'b1, 3'b001, 32'h01, 2'd1);
    fault_req(1'b0, 3'b011, 32'h01, 2'd2);
    fault_req(1'b0, 3'b101, 32'h03, 2'd1);

    // back-to-back fault requests held valid for two cycles
    put_req(1'b0, 3'b010, 32'h02, 32'h0);
    step();
    step();
    req_valid = 1'b0;
    @(negedge clk);
    check("b2b_fault2", 32'(fault_valid), 32'h1);
    step();

    // timeout
    put_req(1'b0, 3'b010, 32'h40, 32'h0);
    step();
    req_valid = 1'b0;
    for (int i = 0; i < TO; i++) begin
      @(negedge clk);
      check("to_mem_req_high", 32'(mem_req), 32'h1);
      step();
    end
    @(negedge clk);
    check("to_fault", 32'(fault_valid), 32'h1);
    check("to_cause", 32'(fault_cause), 32'h3);
    check("to_mem_req_low", 32'(mem_req), 32'h0);
    mem_ack = 1'b1;
    step();
    mem_ack = 1'b0;
    @(negedge clk);
    check("late_ack_no_done", 32'(done_valid), 32'h0);
    check("late_ack_no_req", 32'(mem_req), 32'h0);
    step();

    // directed table, including ack on the last allowed cycle
    for (int i = 0; i < 8; i++) begin
      run_access(vecs[i].st, vecs[i].f3, vecs[i].a, vecs[i].sd, vecs[i].rd, vecs[i].lat, vecs[i].lit);
    end
    step();

    // back-to-back SW 0x0 / LHU 0x2 with ack held high
    mem_ack = 1'b1; mem_rdata = 32'h8001_0000;
    put_req(1'b1, 3'b010, 32'h0, 32'h1357_9BDF);
    step();
    put_req(1'b0, 3'b101, 32'h2, 32'h0);
    @(negedge clk);
    check("b2b_busy", 32'(req_ready), 32'h0);
    step();
    @(negedge clk);
    check("b2b_sw_done", 32'(done_valid), 32'h1);
    check("b2b_ready", 32'(req_ready), 32'h1);
    step();
    req_valid = 1'b0;
    step();
    mem_ack = 1'b0;
    @(negedge clk);
    check("b2b_lhu_done", 32'(done_valid), 32'h1);
    check("b2b_lhu_data", load_data, 32'h0000_8001);
    step();

    // reset in the second ACCESS cycle
    put_req(1'b1, 3'b010, 32'h10, 32'h55);
    step();
    req_valid = 1'b0;
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    @(negedge clk);
    check("mid_rst_req", 32'(mem_req), 32'h0);
    check("mid_rst_done", 32'(done_valid), 32'h0);
    check("mid_rst_fault", 32'(fault_valid), 32'h0);
    check("mid_rst_ready", 32'(req_ready), 32'h1);
    step();
    step();

    check("scoreboard_drain", 32'(exp_q.size()), 32'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
